// File: rtl/vote_result_uart_tx.sv
// Serial read-out of the four vote tallies as an 8N1 UART frame: HEADER, can1..can4.
// Define VOTE_TX_CHECKSUM_EN to append an XOR checksum byte computed from the snapshot.
module vote_result_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       start,
    input  logic [7:0] recev_can1,
    input  logic [7:0] recev_can2,
    input  logic [7:0] recev_can3,
    input  logic [7:0] recev_can4,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef VOTE_TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 6;
`else
    localparam int FRAME_BYTES = 5;
`endif
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        can1_q, can1_d, can2_q, can2_d;
    logic [7:0]        can3_q, can3_d, can4_q, can4_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_last;
    logic              accept;
    logic [7:0]        cur_byte_d;

    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [7:0] c1,
        input logic [7:0] c2,
        input logic [7:0] c3,
        input logic [7:0] c4
    );
        case (idx)
            3'd0:    return HEADER;
            3'd1:    return c1;
            3'd2:    return c2;
            3'd3:    return c3;
            3'd4:    return c4;
`ifdef VOTE_TX_CHECKSUM_EN
            3'd5:    return c1 ^ c2 ^ c3 ^ c4;
`endif
            default: return HEADER;
        endcase
    endfunction

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign accept    = (state_q == IDLE) && start && mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            can1_q  <= '0;
            can2_q  <= '0;
            can3_q  <= '0;
            can4_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            can1_q  <= can1_d;
            can2_q  <= can2_d;
            can3_q  <= can3_d;
            can4_q  <= can4_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Baud counter wraps at CLKS_PER_BIT-1; bit and byte indices advance on the wrap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        can1_d  = can1_q;
        can2_d  = can2_q;
        can3_d  = can3_q;
        can4_d  = can4_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START_BIT;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    can1_d  = recev_can1;
                    can2_d  = recev_can2;
                    can3_d  = recev_can3;
                    can4_d  = recev_can4;
                end
            end
            START_BIT: begin
                if (baud_last) begin
                    state_d = DATA_BITS;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA_BITS: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP_BIT: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q == 3'(FRAME_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = START_BIT;
                        byte_d  = byte_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so tx drops on the accepting edge.
    always_comb begin
        cur_byte_d = frame_byte(byte_d, can1_d, can2_d, can3_d, can4_d);
        tx_d       = 1'b1;
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == STOP_BIT) && (state_d == IDLE);
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = cur_byte_d[bit_d];
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
